multicycle_ctrl_fsm: RTL and testbench

// Main sequencing FSM for the multicycle RV32I core: drives the shared ALU,

---
 rtl/multicycle_ctrl_fsm.sv | 217 +++++++++++++++++++++
 tb/tb_multicycle_ctrl_fsm.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl_fsm.sv
// Main sequencing FSM for the multicycle RV32I core.
// Every datapath control is decoded combinationally from the current state,
// the IR fields (op/funct3/funct7) and the ALU/memory status inputs.
module multicycle_ctrl_fsm #(
  parameter int ST_W = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [6:0]      op,
  input  logic [2:0]      funct3,
  input  logic            funct7,
  input  logic            Zero,
  input  logic            neg,
  input  logic            MemReady,
  output logic            PCWrite,
  output logic            AdrSrc,
  output logic            MemWrite,
  output logic            IRWrite,
  output logic            RegWrite,
  output logic [1:0]      ResultSrc,
  output logic [1:0]      ALUSrcA,
  output logic [1:0]      ALUSrcB,
  output logic [3:0]      ALUControl,
  output logic [1:0]      immSrc,
  output logic            Illegal,
  output logic [ST_W-1:0] state_o
);

  typedef enum logic [ST_W-1:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9,
    JAL      = 4'd10,
    JALR_ADR = 4'd11
  } state_t;

  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_SLL = 4'b0100;
  localparam logic [3:0] ALU_SRL = 4'b0101;
  localparam logic [3:0] ALU_AND = 4'b1000;
  localparam logic [3:0] ALU_OR  = 4'b1001;
  localparam logic [3:0] ALU_XOR = 4'b1010;

  state_t r_state;
  state_t w_next;
  logic   w_taken;

  // funct3/funct7 to ALU operation; sub only exists for register-register ops,
  // and any unsupported combination quietly falls back to add.
  function automatic logic [3:0] alu_dec(input logic [2:0] f3, input logic f7,
                                         input logic allow_sub);
    logic [3:0] res;
    case (f3)
      3'b000:  res = (allow_sub && f7) ? ALU_SUB : ALU_ADD;
      3'b001:  res = ALU_SLL;
      3'b100:  res = ALU_XOR;
      3'b101:  res = ALU_SRL;
      3'b110:  res = ALU_OR;
      3'b111:  res = ALU_AND;
      default: res = ALU_ADD;
    endcase
    return res;
  endfunction

  // State register; reset aborts any instruction in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= FETCH;
    else       r_state <= w_next;
  end

  // Branch condition from the rs1 - rs2 flags.
  always_comb begin
    w_taken = 1'b0;
    case (funct3)
      3'b000:  w_taken = Zero;
      3'b001:  w_taken = ~Zero;
      3'b100:  w_taken = neg;
      3'b101:  w_taken = ~neg | Zero;
      default: w_taken = 1'b0;
    endcase
  end

  // Next-state and output decode; reset forces every output quiet.
  always_comb begin
    w_next     = r_state;
    PCWrite    = 1'b0;
    AdrSrc     = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    RegWrite   = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ALUControl = ALU_ADD;
    Illegal    = 1'b0;

    case (op)
      OP_SW:   immSrc = 2'b01;
      OP_BR:   immSrc = 2'b10;
      OP_JAL:  immSrc = 2'b11;
      default: immSrc = 2'b00;
    endcase

    case (r_state)
      FETCH: begin
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = MemReady;
        PCWrite   = MemReady;
        if (MemReady) w_next = DECODE;
      end
      DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (op)
          OP_LW, OP_SW: w_next = MEMADR;
          OP_R:         w_next = EXECR;
          OP_I:         w_next = EXECI;
          OP_BR:        w_next = BRANCH;
          OP_JAL:       w_next = JAL;
          OP_JALR:      w_next = JALR_ADR;
          default: begin
            Illegal = 1'b1;
            w_next  = FETCH;
          end
        endcase
      end
      MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        if (op == OP_LW)      w_next = MEMREAD;
        else if (op == OP_SW) w_next = MEMWRITE;
        else                  w_next = FETCH;
      end
      MEMREAD: begin
        AdrSrc = 1'b1;
        if (MemReady) w_next = MEMWB;
      end
      MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
        w_next    = FETCH;
      end
      MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
        if (MemReady) w_next = FETCH;
      end
      EXECR: begin
        ALUSrcA    = 2'b10;
        ALUControl = alu_dec(funct3, funct7, 1'b1);
        w_next     = ALUWB;
      end
      EXECI: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        ALUControl = alu_dec(funct3, funct7, 1'b0);
        w_next     = ALUWB;
      end
      ALUWB: begin
        RegWrite = 1'b1;
        w_next   = FETCH;
      end
      BRANCH: begin
        ALUSrcA    = 2'b10;
        ALUControl = ALU_SUB;
        PCWrite    = w_taken;
        w_next     = FETCH;
      end
      JALR_ADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        w_next  = JAL;
      end
      JAL: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        PCWrite = 1'b1;
        w_next  = ALUWB;
      end
      default: w_next = FETCH;
    endcase

    if (reset) begin
      PCWrite    = 1'b0;
      AdrSrc     = 1'b0;
      MemWrite   = 1'b0;
      IRWrite    = 1'b0;
      RegWrite   = 1'b0;
      ResultSrc  = 2'b00;
      ALUSrcA    = 2'b00;
      ALUSrcB    = 2'b00;
      ALUControl = ALU_ADD;
      immSrc     = 2'b00;
      Illegal    = 1'b0;
    end
  end

  assign state_o = r_state;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Directed bench for multicycle_ctrl_fsm: each cycle's expected output vector
// is queued when inputs are driven and compared at the following falling edge.
module tb_multicycle_ctrl_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7, Zero, neg, MemReady;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, Illegal;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, immSrc;
  logic [3:0] ALUControl, state_o;

  always #5 clk = ~clk;

  multicycle_ctrl_fsm #(.ST_W(4)) dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7(funct7),
    .Zero(Zero), .neg(neg), .MemReady(MemReady), .PCWrite(PCWrite),
    .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUControl(ALUControl), .immSrc(immSrc),
    .Illegal(Illegal), .state_o(state_o)
  );

  typedef struct packed {
    logic [3:0] st;
    logic       pcw, adr, mw, irw, rw;
    logic [1:0] rs, a, b;
    logic [3:0] alu;
    logic [1:0] imm;
    logic       ill;
  } exp_t;

  localparam logic [3:0] S_F = 4'd0, S_D = 4'd1, S_MA = 4'd2, S_MR = 4'd3,
                         S_MWB = 4'd4, S_MW = 4'd5, S_ER = 4'd6, S_EI = 4'd7,
                         S_AWB = 4'd8, S_BR = 4'd9, S_JAL = 4'd10, S_JA = 4'd11;

  exp_t  exp_q[$];
  string tag_q[$];
  exp_t  act;
  int    n_tests = 0;
  int    n_fail  = 0;

  assign act = {state_o, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
                ResultSrc, ALUSrcA, ALUSrcB, ALUControl, immSrc, Illegal};

  function automatic exp_t mk(input logic [3:0] st, input logic pcw, adr, mw, irw, rw,
                              input logic [1:0] rs, a, b, input logic [3:0] alu,
                              input logic [1:0] imm, input logic ill);
    exp_t e;
    e = {st, pcw, adr, mw, irw, rw, rs, a, b, alu, imm, ill};
    return e;
  endfunction

  function automatic exp_t fetch_e(input logic mr, input logic [1:0] imm);
    return mk(S_F, mr, 1'b0, 1'b0, mr, 1'b0, 2'b10, 2'b00, 2'b10, 4'b0000, imm, 1'b0);
  endfunction

  function automatic exp_t decode_e(input logic [1:0] imm, input logic ill);
    return mk(S_D, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 4'b0000, imm, ill);
  endfunction

  task automatic set_in(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                        input logic z, input logic n, input logic mr);
    op = o; funct3 = f3; funct7 = f7; Zero = z; neg = n; MemReady = mr;
  endtask

  task automatic check_out();
    exp_t  e;
    string t;
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty: observed %h required an expectation", act);
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      assert (act === e) else begin
        n_fail++;
        $error("FAIL %s: observed %h required %h", t, act, e);
      end
    end
  endtask

  // One clock cycle: queue expectation, compare at falling edge, move past next rising edge.
  task automatic cyc(input string t, input exp_t e);
    tag_q.push_back(t);
    exp_q.push_back(e);
    @(negedge clk);
    check_out();
    @(posedge clk);
    #1;
  endtask

  // Immediate check (for asynchronous reset effects).
  task automatic now(input string t, input exp_t e);
    tag_q.push_back(t);
    exp_q.push_back(e);
    #1;
    check_out();
  endtask

  initial begin
    reset = 1'b1;
    set_in(7'b0110011, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1);
    @(posedge clk); #1;
    // Reset: everything quiet even with MemReady high.
    cyc("reset_0", mk(S_F, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    cyc("reset_1", mk(S_F, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    reset = 1'b0;

    // add x3,x1,x2
    cyc("add_fetch",  fetch_e(1, 2'b00));
    cyc("add_decode", decode_e(2'b00, 0));
    cyc("add_execr",  mk(S_ER, 0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 4'b0000, 0, 0));
    cyc("add_aluwb",  mk(S_AWB, 0, 0, 0, 0, 1, 0, 0, 0, 4'b0000, 0, 0));
    // sub
    set_in(7'b0110011, 3'b000, 1'b1, 1'b0, 1'b0, 1'b1);
    cyc("sub_fetch",  fetch_e(1, 2'b00));
    cyc("sub_decode", decode_e(2'b00, 0));
    cyc("sub_execr",  mk(S_ER, 0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 4'b0001, 0, 0));
    cyc("sub_aluwb",  mk(S_AWB, 0, 0, 0, 0, 1, 0, 0, 0, 4'b0000, 0, 0));
    // R-type and (f3 111)
    set_in(7'b0110011, 3'b111, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc("and_fetch",  fetch_e(1, 2'b00));
    cyc("and_decode", decode_e(2'b00, 0));
    cyc("and_execr",  mk(S_ER, 0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 4'b1000, 0, 0));
    cyc("and_aluwb",  mk(S_AWB, 0, 0, 0, 0, 1, 0, 0, 0, 4'b0000, 0, 0));
    // R-type f3 010 -> add, not illegal
    set_in(7'b0110011, 3'b010, 1'b1, 1'b0, 1'b0, 1'b1);
    cyc("r010_fetch",  fetch_e(1, 2'b00));
    cyc("r010_decode", decode_e(2'b00, 0));
    cyc("r010_execr",  mk(S_ER, 0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 4'b0000, 0, 0));
    cyc("r010_aluwb",  mk(S_AWB, 0, 0, 0, 0, 1, 0, 0, 0, 4'b0000, 0, 0));
    // addi with funct7=1 -> add (no sub for immediates)
    set_in(7'b0010011, 3'b000, 1'b1, 1'b0, 1'b0, 1'b1);
    cyc("addi_fetch",  fetch_e(1, 2'b00));
    cyc("addi_decode", decode_e(2'b00, 0));
    cyc("addi_execi",  mk(S_EI, 0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 4'b0000, 0, 0));
    cyc("addi_aluwb",  mk(S_AWB, 0, 0, 0, 0, 1, 0, 0, 0, 4'b0000, 0, 0));
    // srli (f3 101) and xori (f3 100)
    set_in(7'b0010011, 3'b101, 1'b1, 1'b0, 1'b0, 1'b1);
    cyc("srli_fetch",  fetch_e(1, 2'b00));
    cyc("srli_decode", decode_e(2'b00, 0));
    cyc("srli_execi",  mk(S_EI, 0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 4'b0101, 0, 0));
    cyc("srli_aluwb",  mk(S_AWB, 0, 0, 0, 0, 1, 0, 0, 0, 4'b0000, 0, 0));
    set_in(7'b0010011, 3'b100, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc("xori_fetch",  fetch_e(1, 2'b00));
    cyc("xori_decode", decode_e(2'b00, 0));
    cyc("xori_execi",  mk(S_EI, 0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 4'b1010, 0, 0));
    cyc("xori_aluwb",  mk(S_AWB, 0, 0, 0, 0, 1, 0, 0, 0, 4'b0000, 0, 0));

    // lw with one fetch wait and two MEMREAD waits
    set_in(7'b0000011, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc("lw_fetch_wait", fetch_e(0, 2'b00));
    MemReady = 1'b1;
    cyc("lw_fetch",   fetch_e(1, 2'b00));
    cyc("lw_decode",  decode_e(2'b00, 0));
    MemReady = 1'b0;
    cyc("lw_memadr",  mk(S_MA, 0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 0, 0, 0));
    cyc("lw_memrd_w0", mk(S_MR, 0, 1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0));
    cyc("lw_memrd_w1", mk(S_MR, 0, 1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0));
    MemReady = 1'b1;
    cyc("lw_memrd",   mk(S_MR, 0, 1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0));
    cyc("lw_memwb",   mk(S_MWB, 0, 0, 0, 0, 1, 2'b01, 0, 0, 0, 0, 0));

    // sw with one MEMWRITE wait
    set_in(7'b0100011, 3'b010, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc("sw_fetch",   fetch_e(1, 2'b01));
    cyc("sw_decode",  decode_e(2'b01, 0));
    MemReady = 1'b0;
    cyc("sw_memadr",  mk(S_MA, 0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 0, 2'b01, 0));
    cyc("sw_memwr_w", mk(S_MW, 0, 1, 1, 0, 0, 0, 0, 0, 0, 2'b01, 0));
    MemReady = 1'b1;
    cyc("sw_memwr",   mk(S_MW, 0, 1, 1, 0, 0, 0, 0, 0, 0, 2'b01, 0));

    // sw aborted by reset in MEMWRITE
    cyc("sw2_fetch",  fetch_e(1, 2'b01));
    cyc("sw2_decode", decode_e(2'b01, 0));
    MemReady = 1'b0;
    cyc("sw2_memadr", mk(S_MA, 0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 0, 2'b01, 0));
    cyc("sw2_memwr_w", mk(S_MW, 0, 1, 1, 0, 0, 0, 0, 0, 0, 2'b01, 0));
    now("sw2_memwr_pre", mk(S_MW, 0, 1, 1, 0, 0, 0, 0, 0, 0, 2'b01, 0));
    reset = 1'b1;
    now("rst_mid_memwrite", mk(S_F, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    cyc("rst_hold",   mk(S_F, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    reset = 1'b0;
    cyc("post_rst_wait0", fetch_e(0, 2'b01));
    cyc("post_rst_wait1", fetch_e(0, 2'b01));
    MemReady = 1'b1;
    cyc("post_rst_fetch", fetch_e(1, 2'b01));
    cyc("sw3_decode", decode_e(2'b01, 0));
    cyc("sw3_memadr", mk(S_MA, 0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 0, 2'b01, 0));
    cyc("sw3_memwr",  mk(S_MW, 0, 1, 1, 0, 0, 0, 0, 0, 0, 2'b01, 0));

    // beq taken (Zero=1)
    set_in(7'b1100011, 3'b000, 1'b0, 1'b1, 1'b0, 1'b1);
    cyc("beq_fetch",  fetch_e(1, 2'b10));
    cyc("beq_decode", decode_e(2'b10, 0));
    cyc("beq_branch", mk(S_BR, 1, 0, 0, 0, 0, 0, 2'b10, 2'b00, 4'b0001, 2'b10, 0));
    // bge with neg=1, Zero=0 -> not taken
    set_in(7'b1100011, 3'b101, 1'b0, 1'b0, 1'b1, 1'b1);
    cyc("bge_fetch",  fetch_e(1, 2'b10));
    cyc("bge_decode", decode_e(2'b10, 0));
    cyc("bge_branch", mk(S_BR, 0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 4'b0001, 2'b10, 0));
    // blt with neg=1 -> taken
    set_in(7'b1100011, 3'b100, 1'b0, 1'b0, 1'b1, 1'b1);
    cyc("blt_fetch",  fetch_e(1, 2'b10));
    cyc("blt_decode", decode_e(2'b10, 0));
    cyc("blt_branch", mk(S_BR, 1, 0, 0, 0, 0, 0, 2'b10, 2'b00, 4'b0001, 2'b10, 0));
    // bne with Zero=1 -> not taken
    set_in(7'b1100011, 3'b001, 1'b0, 1'b1, 1'b0, 1'b1);
    cyc("bne_fetch",  fetch_e(1, 2'b10));
    cyc("bne_decode", decode_e(2'b10, 0));
    cyc("bne_branch", mk(S_BR, 0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 4'b0001, 2'b10, 0));

    // jalr
    set_in(7'b1100111, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc("jalr_fetch",  fetch_e(1, 2'b00));
    cyc("jalr_decode", decode_e(2'b00, 0));
    cyc("jalr_adr",    mk(S_JA, 0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 0, 0, 0));
    cyc("jalr_jal",    mk(S_JAL, 1, 0, 0, 0, 0, 0, 2'b01, 2'b10, 0, 0, 0));
    cyc("jalr_aluwb",  mk(S_AWB, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    // jal
    set_in(7'b1101111, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc("jal_fetch",  fetch_e(1, 2'b11));
    cyc("jal_decode", decode_e(2'b11, 0));
    cyc("jal_jal",    mk(S_JAL, 1, 0, 0, 0, 0, 0, 2'b01, 2'b10, 0, 2'b11, 0));
    cyc("jal_aluwb",  mk(S_AWB, 0, 0, 0, 0, 1, 0, 0, 0, 0, 2'b11, 0));

    // Illegal opcode: one-cycle pulse in DECODE, back to FETCH
    set_in(7'b1111111, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc("ill_fetch",  fetch_e(1, 2'b00));
    cyc("ill_decode", decode_e(2'b00, 1));
    MemReady = 1'b0;
    cyc("ill_after",  fetch_e(0, 2'b00));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
